// File: rtl/axil_uart_fifo_regs.sv
// Register front-end for the UART core: AXI4-Lite slave with TX/RX byte FIFOs, sticky/level ISR and masked IRQ.
// Define AXIL_UART_FIFO_REGS_RXTO_EN to add the RX idle-timeout register (0x20) and ISR[9].

// Generic synchronous FIFO with first-word-fall-through head and level output.
// Latency: a push is visible at head/level on the next cycle; flush empties on the next cycle.
// Backpressure: caller must gate push with !full and pop with !empty; flush overrides both.
module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end
endmodule

// AXI4-Lite register block for the UART with TX/RX FIFOs, W1C interrupt status and registered IRQ.
// Latency: one write per two cycles (response the cycle after accept); reads return registered data the cycle after accept.
// Backpressure: accepts stall while B/R is held by the master; RX stream stalls when the RX FIFO is full.
module axil_uart_fifo_regs #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int AXIS_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    s_axil_awaddr,
    input  logic                 s_axil_awvalid,
    output logic                 s_axil_awready,
    input  logic [DATA_W-1:0]    s_axil_wdata,
    input  logic [DATA_W/8-1:0]  s_axil_wstrb,
    input  logic                 s_axil_wvalid,
    output logic                 s_axil_wready,
    output logic [1:0]           s_axil_bresp,
    output logic                 s_axil_bvalid,
    input  logic                 s_axil_bready,
    input  logic [ADDR_W-1:0]    s_axil_araddr,
    input  logic                 s_axil_arvalid,
    output logic                 s_axil_arready,
    output logic [DATA_W-1:0]    s_axil_rdata,
    output logic [1:0]           s_axil_rresp,
    output logic                 s_axil_rvalid,
    input  logic                 s_axil_rready,
    output logic [AXIS_W-1:0]    m_axis_tx_tdata,
    output logic                 m_axis_tx_tvalid,
    input  logic                 m_axis_tx_tready,
    input  logic [AXIS_W-1:0]    s_axis_rx_tdata,
    input  logic                 s_axis_rx_tvalid,
    output logic                 s_axis_rx_tready,
    output logic [30:0]          o_ctrl,
    input  logic [3:0]           i_evt,
    output logic                 o_irq
);
    localparam int TXL = $clog2(TX_DEPTH) + 1;
    localparam int RXL = $clog2(RX_DEPTH) + 1;

    localparam logic [7:0] A_CTRL  = 8'h00;
    localparam logic [7:0] A_ISR   = 8'h04;
    localparam logic [7:0] A_ICR   = 8'h08;
    localparam logic [7:0] A_IER   = 8'h0C;
    localparam logic [7:0] A_TXD   = 8'h10;
    localparam logic [7:0] A_RXD   = 8'h14;
    localparam logic [7:0] A_LVL   = 8'h18;
    localparam logic [7:0] A_RXTHR = 8'h1C;

    logic [7:0]        wr_addr;
    logic [7:0]        rd_addr;
    logic              wr_acc;
    logic              rd_acc;
    logic              wr_err;
    logic              rd_err;
    logic [DATA_W-1:0] rd_dat;

    logic [9:0]        ier;
    logic [15:0]       rxthr;
    logic [3:0]        evt_st;
    logic              txovf_st;
    logic              rto_st;
    logic              rxne_q, txe_q, txnf_q, rxft_q;
    logic [DATA_W-1:0] isr_val;
    logic [9:0]        icr_clr;

    logic              flush;
    logic              tx_push, tx_pop, tx_full, tx_empty, tx_ovf;
    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [AXIS_W-1:0] rx_head;
    logic [TXL-1:0]    tx_level;
    logic [RXL-1:0]    rx_level;

    logic              unused_bits;
    assign unused_bits = ^{s_axil_wstrb, s_axil_awaddr[ADDR_W-1:8], s_axil_araddr[ADDR_W-1:8]};

    assign wr_addr = s_axil_awaddr[7:0];
    assign rd_addr = s_axil_araddr[7:0];

    // awready doubles as the "accept pending" flag, so writes are spaced by two cycles.
    assign wr_acc = s_axil_awvalid && s_axil_wvalid && !s_axil_awready
                    && (!s_axil_bvalid || s_axil_bready);
    assign rd_acc = s_axil_arvalid && !s_axil_arready
                    && (!s_axil_rvalid || s_axil_rready);

    assign flush   = wr_acc && (wr_addr == A_CTRL) && s_axil_wdata[31];
    assign icr_clr = (wr_acc && (wr_addr == A_ICR)) ? s_axil_wdata[9:0] : 10'd0;

    assign tx_ovf  = wr_acc && (wr_addr == A_TXD) && tx_full;
    assign tx_push = wr_acc && (wr_addr == A_TXD) && !tx_full;
    assign tx_pop  = m_axis_tx_tvalid && m_axis_tx_tready;
    assign rx_push = s_axis_rx_tvalid && s_axis_rx_tready;
    assign rx_pop  = rd_acc && (rd_addr == A_RXD) && !rx_empty;

    assign m_axis_tx_tvalid = !tx_empty;
    assign s_axis_rx_tready = !rx_full;

    uart_fifo #(.W(AXIS_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (s_axil_wdata[AXIS_W-1:0]),
        .head  (m_axis_tx_tdata),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_fifo #(.W(AXIS_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (s_axis_rx_tdata),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

`ifdef AXIL_UART_FIFO_REGS_RXTO_EN
    localparam logic [7:0] A_RXTO = 8'h20;
    logic [15:0] rxto;
    logic [15:0] rto_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxto    <= '0;
            rto_cnt <= '0;
            rto_st  <= 1'b0;
        end else begin
            if (wr_acc && (wr_addr == A_RXTO)) rxto <= s_axil_wdata[15:0];
            if (rx_push || rx_pop || rx_empty) rto_cnt <= '0;
            else if (rto_cnt != 16'hFFFF)      rto_cnt <= rto_cnt + 16'd1;
            rto_st <= (rto_st && !icr_clr[9]) || ((rxto != 16'd0) && (rto_cnt == rxto));
        end
    end
`else
    assign rto_st = 1'b0;
`endif

    assign isr_val = {22'd0, rto_st, txovf_st, rxft_q, txnf_q, txe_q, rxne_q, evt_st};

    always_comb begin
        case (wr_addr)
            A_CTRL, A_ICR, A_IER, A_RXTHR: wr_err = 1'b0;
            A_TXD:                         wr_err = tx_full;
`ifdef AXIL_UART_FIFO_REGS_RXTO_EN
            A_RXTO:                        wr_err = 1'b0;
`endif
            default:                       wr_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_dat = '0;
        rd_err = 1'b0;
        case (rd_addr)
            A_CTRL:  rd_dat = {1'b0, o_ctrl};
            A_ISR:   rd_dat = isr_val;
            A_IER:   rd_dat = {22'd0, ier};
            A_RXD:   rd_dat = rx_empty ? '0 : 32'(rx_head);
            A_LVL:   rd_dat = {16'(rx_level), 16'(tx_level)};
            A_RXTHR: rd_dat = {16'd0, rxthr};
`ifdef AXIL_UART_FIFO_REGS_RXTO_EN
            A_RXTO:  rd_dat = {16'd0, rxto};
`endif
            default: rd_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axil_awready <= 1'b0;
            s_axil_wready  <= 1'b0;
            s_axil_bvalid  <= 1'b0;
            s_axil_bresp   <= 2'b00;
            s_axil_arready <= 1'b0;
            s_axil_rvalid  <= 1'b0;
            s_axil_rresp   <= 2'b00;
            s_axil_rdata   <= '0;
        end else begin
            s_axil_awready <= wr_acc;
            s_axil_wready  <= wr_acc;
            if (wr_acc) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= wr_err ? 2'b10 : 2'b00;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
            s_axil_arready <= rd_acc;
            if (rd_acc) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rresp  <= rd_err ? 2'b10 : 2'b00;
                s_axil_rdata  <= rd_dat;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    // Sticky bits: a set landing in the same cycle as its ICR clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ctrl   <= '0;
            ier      <= '0;
            rxthr    <= '0;
            evt_st   <= '0;
            txovf_st <= 1'b0;
            rxne_q   <= 1'b0;
            txe_q    <= 1'b0;
            txnf_q   <= 1'b0;
            rxft_q   <= 1'b0;
            o_irq    <= 1'b0;
        end else begin
            if (wr_acc && (wr_addr == A_CTRL))  o_ctrl <= s_axil_wdata[30:0];
            if (wr_acc && (wr_addr == A_IER))   ier    <= s_axil_wdata[9:0];
            if (wr_acc && (wr_addr == A_RXTHR)) rxthr  <= s_axil_wdata[15:0];
            evt_st   <= (evt_st & ~icr_clr[3:0]) | i_evt;
            txovf_st <= (txovf_st && !icr_clr[8]) || tx_ovf;
            rxne_q   <= !rx_empty;
            txe_q    <= tx_empty;
            txnf_q   <= !tx_full;
            rxft_q   <= (rxthr != 16'd0) && (16'(rx_level) >= rxthr);
            o_irq    <= |(isr_val[9:0] & ier);
        end
    end
endmodule
